// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : two-port round-robin arbiter and access sequencer that
//               serialises A/B requests onto the 8x8 memory system port.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       we_a,
    input  logic       we_b,
    input  logic [2:0] addr_a,
    input  logic [2:0] addr_b,
    input  logic [7:0] wdata_a,
    input  logic [7:0] wdata_b,
    output logic       ack_a,
    output logic       ack_b,
    output logic [7:0] rdata_a,
    output logic [7:0] rdata_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       busy,
    output logic       mem_select,
    output logic       mem_op,
    output logic [2:0] mem_address,
    output logic [7:0] mem_data_in,
    input  logic [7:0] mem_data_out
);

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_ISSUE = 2'd1;
    localparam logic [1:0] C_ST_WAIT  = 2'd2;
    localparam logic [1:0] C_ST_DONE  = 2'd3;

    localparam logic       C_PORT_A   = 1'b0;
    localparam logic       C_PORT_B   = 1'b1;
    localparam logic [3:0] C_CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic       win_q, win_d;
    logic       cmd_we_q, cmd_we_d;
    logic [2:0] cmd_addr_q, cmd_addr_d;
    logic [7:0] cmd_wdata_q, cmd_wdata_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rdata_a_q, rdata_a_d;
    logic [7:0] rdata_b_q, rdata_b_d;

    logic       w_any_req;
    logic       w_pick_b;

    // B wins only when A is idle or A was the most recent port served.
    assign w_any_req = req_a | req_b;
    assign w_pick_b  = req_b & (~req_a | (last_q == C_PORT_A));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE:  if (w_any_req) state_d = C_ST_ISSUE;
            C_ST_ISSUE: state_d = C_ST_WAIT;
            C_ST_WAIT:  if (cnt_q == 4'd0) state_d = C_ST_DONE;
            C_ST_DONE:  state_d = C_ST_IDLE;
            default:    state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin
        last_d      = last_q;
        win_d       = win_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cnt_d       = cnt_q;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;
        case (state_q)
            C_ST_IDLE: begin
                if (w_any_req) begin
                    win_d       = w_pick_b;
                    last_d      = w_pick_b;
                    cmd_we_d    = w_pick_b ? we_b    : we_a;
                    cmd_addr_d  = w_pick_b ? addr_b  : addr_a;
                    cmd_wdata_d = w_pick_b ? wdata_b : wdata_a;
                end
            end
            C_ST_ISSUE: begin
                cnt_d = C_CNT_LOAD;
            end
            C_ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Read data is only valid on the final WAIT cycle.
                    if (!cmd_we_q) begin
                        if (win_q == C_PORT_B) begin
                            rdata_b_d = mem_data_out;
                        end else begin
                            rdata_a_d = mem_data_out;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= C_PORT_B;
            win_q       <= C_PORT_A;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= 3'd0;
            cmd_wdata_q <= 8'd0;
            cnt_q       <= 4'd0;
            rdata_a_q   <= 8'd0;
            rdata_b_q   <= 8'd0;
        end else begin
            last_q      <= last_d;
            win_q       <= win_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cnt_q       <= cnt_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
        end
    end

    always_comb begin
        busy       = (state_q != C_ST_IDLE);
        mem_select = (state_q == C_ST_ISSUE);
        gnt_a      = busy & (win_q == C_PORT_A);
        gnt_b      = busy & (win_q == C_PORT_B);
        ack_a      = (state_q == C_ST_DONE) & (win_q == C_PORT_A);
        ack_b      = (state_q == C_ST_DONE) & (win_q == C_PORT_B);
    end

    // The command register holds its value between accesses; select qualifies it.
    assign mem_op      = cmd_we_q;
    assign mem_address = cmd_addr_q;
    assign mem_data_in = cmd_wdata_q;
    assign rdata_a     = rdata_a_q;
    assign rdata_b     = rdata_b_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : scoreboard bench for mem_arbiter (ACCESS_CYCLES = 2 and 1).
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

    typedef struct {
        logic       port;
        logic       we;
        logic [7:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b, we_a, we_b;
    logic [2:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;

    logic       ack_a, ack_b, gnt_a, gnt_b, busy, mem_select, mem_op;
    logic [7:0] rdata_a, rdata_b, mem_data_in, mem_data_out;
    logic [2:0] mem_address;

    logic       ack_a1, ack_b1, gnt_a1, gnt_b1, busy1, mem_select1, mem_op1;
    logic [7:0] rdata_a1, rdata_b1, mem_data_in1, mem_data_out1;
    logic [2:0] mem_address1;

    logic [7:0] mem0 [8] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
    logic [7:0] mem1 [8] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
    logic [7:0] ref0 [8] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
    logic [2:0] m0_addr = 3'd0;
    logic [2:0] m1_addr = 3'd0;
    int         m0_age  = 100;
    int         m1_age  = 100;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc = 0, sel_cnt = 0, sel_cyc = 0, prev_sel_cyc = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ACCESS_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy),
        .mem_select(mem_select), .mem_op(mem_op), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    mem_arbiter #(.ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a1), .ack_b(ack_b1), .rdata_a(rdata_a1), .rdata_b(rdata_b1),
        .gnt_a(gnt_a1), .gnt_b(gnt_b1), .busy(busy1),
        .mem_select(mem_select1), .mem_op(mem_op1), .mem_address(mem_address1),
        .mem_data_in(mem_data_in1), .mem_data_out(mem_data_out1)
    );

    // Memory models: data_out is valid only on the last cycle of the access window.
    always @(posedge clk) begin
        if (mem_select) begin
            if (mem_op) mem0[mem_address] <= mem_data_in;
            m0_addr <= mem_address;
            m0_age  <= 0;
        end else if (m0_age < 100) begin
            m0_age <= m0_age + 1;
        end
    end
    assign mem_data_out = (m0_age == 1) ? mem0[m0_addr] : 8'hEE;

    always @(posedge clk) begin
        if (mem_select1) begin
            if (mem_op1) mem1[mem_address1] <= mem_data_in1;
            m1_addr <= mem_address1;
            m1_age  <= 0;
        end else if (m1_age < 100) begin
            m1_age <= m1_age + 1;
        end
    end
    assign mem_data_out1 = (m1_age == 0) ? mem1[m1_addr] : 8'hEE;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_select) begin
            prev_sel_cyc = sel_cyc;
            sel_cyc      = cyc;
            sel_cnt++;
        end
    endtask

    task automatic wait_ack(input int limit, output logic got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            tick();
            if (ack_a || ack_b) got = 1'b1;
        end
    endtask

    task automatic apply_reset();
        req_a = 1'b0; req_b = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        sb_q.delete();
    endtask

    task automatic test_reset();
        logic bad;
        req_a = 1'b1; req_b = 1'b1; we_a = 1'b1; we_b = 1'b0;
        addr_a = 3'd5; addr_b = 3'd2; wdata_a = 8'hFF; wdata_b = 8'h0F;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({ack_a, ack_b, gnt_a, gnt_b, busy, mem_select, mem_op, mem_address, mem_data_in, rdata_a, rdata_b} !== 34'd0)
            $display("FAIL reset_outputs: got %h required 0",
                     {ack_a, ack_b, gnt_a, gnt_b, busy, mem_select, mem_op, mem_address, mem_data_in, rdata_a, rdata_b});
        else n_pass++;
        n_checks++;
        if ({ack_a1, ack_b1, gnt_a1, gnt_b1, busy1, mem_select1, mem_op1, mem_address1, mem_data_in1, rdata_a1, rdata_b1} !== 34'd0)
            $display("FAIL reset_outputs_ac1: got %h required 0",
                     {ack_a1, ack_b1, gnt_a1, gnt_b1, busy1, mem_select1, mem_op1, mem_address1, mem_data_in1, rdata_a1, rdata_b1});
        else n_pass++;
        req_a = 1'b0; req_b = 1'b0;
        rst_n = 1'b1;
        sel_cnt = 0;
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad || sel_cnt != 0)
            $display("FAIL idle_after_reset: busy_seen=%0b selects=%0d required 0/0", bad, sel_cnt);
        else n_pass++;
    endtask

    task automatic test_write_read_a();
        logic got;
        exp_t e;
        apply_reset();
        we_a = 1'b1; addr_a = 3'd3; wdata_a = 8'hA5; req_a = 1'b1;
        ref0[3] = 8'hA5;
        sb_q.push_back('{port: 1'b0, we: 1'b1, rdata: 8'h00});
        cyc = 0;
        tick();
        n_checks++;
        if ({mem_select, mem_op, mem_address, mem_data_in, gnt_a, gnt_b} !== {1'b1, 1'b1, 3'd3, 8'hA5, 1'b1, 1'b0})
            $display("FAIL wr_issue: got sel=%b op=%b addr=%0d din=%h gnt=%b%b required 1 1 3 a5 10",
                     mem_select, mem_op, mem_address, mem_data_in, gnt_a, gnt_b);
        else n_pass++;
        wait_ack(10, got);
        n_checks++;
        if (!got || cyc != 4 || sb_q.size() == 0)
            $display("FAIL wr_ack_cycle: got ack=%b at cycle %0d required ack in cycle 4", got, cyc);
        else begin
            e = sb_q.pop_front();
            if ({ack_b, ack_a} !== (e.port ? 2'b10 : 2'b01))
                $display("FAIL wr_ack_port: got ack_b/ack_a=%b%b required port %0d", ack_b, ack_a, e.port);
            else n_pass++;
        end
        req_a = 1'b0;
        tick();
        we_a = 1'b0; req_a = 1'b1;
        sb_q.push_back('{port: 1'b0, we: 1'b0, rdata: ref0[3]});
        cyc = 0;
        wait_ack(10, got);
        n_checks++;
        if (!got || sb_q.size() == 0)
            $display("FAIL rd_a_timeout: no ack within 10 cycles");
        else begin
            e = sb_q.pop_front();
            if (ack_a !== 1'b1 || cyc != 4 || rdata_a !== e.rdata)
                $display("FAIL rd_a_data: got ack_a=%b cycle=%0d rdata_a=%h required 1 4 %h", ack_a, cyc, rdata_a, e.rdata);
            else n_pass++;
        end
        req_a = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic got;
        exp_t e;
        apply_reset();
        we_a = 1'b1; addr_a = 3'd0; wdata_a = 8'h11;
        we_b = 1'b1; addr_b = 3'd7; wdata_b = 8'h22;
        req_a = 1'b1; req_b = 1'b1;
        ref0[0] = 8'h11; ref0[7] = 8'h22;
        sb_q.push_back('{port: 1'b0, we: 1'b1, rdata: 8'h00});
        sb_q.push_back('{port: 1'b1, we: 1'b1, rdata: 8'h00});
        cyc = 0;
        for (int t = 0; t < 2; t++) begin
            wait_ack(12, got);
            n_checks++;
            if (!got || sb_q.size() == 0)
                $display("FAIL sim_wr_timeout: transaction %0d not acknowledged", t);
            else begin
                e = sb_q.pop_front();
                if ({ack_b, ack_a} !== (e.port ? 2'b10 : 2'b01))
                    $display("FAIL sim_wr_order: got ack_b/ack_a=%b%b required port %0d", ack_b, ack_a, e.port);
                else n_pass++;
                if (e.port) req_b = 1'b0; else req_a = 1'b0;
            end
        end
        n_checks++;
        if (sel_cyc - prev_sel_cyc != 5)
            $display("FAIL sim_sel_spacing: got %0d cycles required 5", sel_cyc - prev_sel_cyc);
        else n_pass++;
        tick();
        we_a = 1'b0; we_b = 1'b0; req_a = 1'b1; req_b = 1'b1;
        sb_q.push_back('{port: 1'b0, we: 1'b0, rdata: ref0[0]});
        sb_q.push_back('{port: 1'b1, we: 1'b0, rdata: ref0[7]});
        for (int t = 0; t < 2; t++) begin
            wait_ack(12, got);
            n_checks++;
            if (!got || sb_q.size() == 0)
                $display("FAIL sim_rd_timeout: transaction %0d not acknowledged", t);
            else begin
                e = sb_q.pop_front();
                if ({ack_b, ack_a} !== (e.port ? 2'b10 : 2'b01) || (e.port ? rdata_b : rdata_a) !== e.rdata)
                    $display("FAIL sim_rd_data: got ack=%b%b rdata=%h required port %0d rdata %h",
                             ack_b, ack_a, e.port ? rdata_b : rdata_a, e.port, e.rdata);
                else n_pass++;
                if (e.port) req_b = 1'b0; else req_a = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic       got;
        exp_t       e;
        logic [7:0] prev_a, prev_b;
        apply_reset();
        we_a = 1'b0; we_b = 1'b0; addr_a = 3'd1; addr_b = 3'd5;
        req_a = 1'b1; req_b = 1'b1;
        sb_q.push_back('{port: 1'b0, we: 1'b0, rdata: ref0[1]});
        sb_q.push_back('{port: 1'b1, we: 1'b0, rdata: ref0[5]});
        sb_q.push_back('{port: 1'b0, we: 1'b0, rdata: ref0[2]});
        sb_q.push_back('{port: 1'b1, we: 1'b0, rdata: ref0[6]});
        prev_a = rdata_a; prev_b = rdata_b;
        for (int t = 0; t < 4; t++) begin
            wait_ack(12, got);
            n_checks++;
            if (!got || sb_q.size() == 0)
                $display("FAIL b2b_timeout: transaction %0d not acknowledged", t);
            else begin
                e = sb_q.pop_front();
                if ({ack_b, ack_a} !== (e.port ? 2'b10 : 2'b01) || (e.port ? rdata_b : rdata_a) !== e.rdata)
                    $display("FAIL b2b_grant: txn %0d got ack=%b%b rdata=%h required port %0d rdata %h",
                             t, ack_b, ack_a, e.port ? rdata_b : rdata_a, e.port, e.rdata);
                else n_pass++;
                n_checks++;
                if ((e.port ? rdata_a : rdata_b) !== (e.port ? prev_a : prev_b))
                    $display("FAIL b2b_loser_rdata: txn %0d got %h required %h",
                             t, e.port ? rdata_a : rdata_b, e.port ? prev_a : prev_b);
                else n_pass++;
                if (e.port) begin addr_b = 3'd6; prev_b = rdata_b; end
                else        begin addr_a = 3'd2; prev_a = rdata_a; end
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        logic got;
        exp_t e;
        logic bad;
        apply_reset();
        we_b = 1'b0; addr_b = 3'd7; req_b = 1'b1;
        sb_q.push_back('{port: 1'b1, we: 1'b0, rdata: ref0[7]});
        wait_ack(10, got);
        n_checks++;
        if (!got || sb_q.size() == 0)
            $display("FAIL mid_pre_read: no ack within 10 cycles");
        else begin
            e = sb_q.pop_front();
            if (ack_b !== 1'b1 || rdata_b !== e.rdata)
                $display("FAIL mid_pre_read: got ack_b=%b rdata_b=%h required 1 %h", ack_b, rdata_b, e.rdata);
            else n_pass++;
        end
        req_b = 1'b0;
        tick();
        addr_b = 3'd6; req_b = 1'b1;
        bad = 1'b0;
        tick();
        tick();
        if (ack_b !== 1'b0) bad = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, gnt_b, mem_select, mem_address, rdata_b} !== 14'd0)
            $display("FAIL mid_reset_outputs: got busy=%b gnt_b=%b sel=%b addr=%0d rdata_b=%h required all 0",
                     busy, gnt_b, mem_select, mem_address, rdata_b);
        else n_pass++;
        req_b = 1'b0;
        repeat (3) begin
            tick();
            if (ack_b !== 1'b0) bad = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            if (ack_b !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad || rdata_b !== 8'h00)
            $display("FAIL mid_no_ack: got ack_b_seen=%b rdata_b=%h required 0 00", bad, rdata_b);
        else n_pass++;
        we_a = 1'b0; addr_a = 3'd0; req_a = 1'b1; req_b = 1'b1; addr_b = 3'd7;
        sb_q.push_back('{port: 1'b0, we: 1'b0, rdata: ref0[0]});
        sb_q.push_back('{port: 1'b1, we: 1'b0, rdata: ref0[7]});
        tick();
        n_checks++;
        if ({gnt_a, gnt_b, mem_select} !== 3'b101)
            $display("FAIL mid_regrant: got gnt_a/gnt_b/sel=%b%b%b required 101", gnt_a, gnt_b, mem_select);
        else n_pass++;
        for (int t = 0; t < 2; t++) begin
            wait_ack(12, got);
            n_checks++;
            if (!got || sb_q.size() == 0)
                $display("FAIL mid_drain: transaction %0d not acknowledged", t);
            else begin
                e = sb_q.pop_front();
                if ({ack_b, ack_a} !== (e.port ? 2'b10 : 2'b01) || (e.port ? rdata_b : rdata_a) !== e.rdata)
                    $display("FAIL mid_drain: got ack=%b%b rdata=%h required port %0d rdata %h",
                             ack_b, ack_a, e.port ? rdata_b : rdata_a, e.port, e.rdata);
                else n_pass++;
                if (e.port) req_b = 1'b0; else req_a = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_short_latency();
        exp_t e;
        apply_reset();
        we_a = 1'b1; addr_a = 3'd4; wdata_a = 8'h5A; req_a = 1'b1;
        sb_q.push_back('{port: 1'b0, we: 1'b1, rdata: 8'h00});
        cyc = 0;
        for (int i = 0; i < 10 && !ack_a1; i++) tick();
        n_checks++;
        if (ack_a1 !== 1'b1 || cyc != 3 || sb_q.size() == 0)
            $display("FAIL ac1_wr_ack: got ack_a=%b at cycle %0d required ack in cycle 3", ack_a1, cyc);
        else begin
            e = sb_q.pop_front();
            if (e.port !== 1'b0 || ack_b1 !== 1'b0)
                $display("FAIL ac1_wr_ack: got ack_b=%b required 0", ack_b1);
            else n_pass++;
        end
        req_a = 1'b0;
        tick();
        we_a = 1'b0; req_a = 1'b1;
        sb_q.push_back('{port: 1'b0, we: 1'b0, rdata: 8'h5A});
        cyc = 0;
        tick();
        n_checks++;
        if (mem_select1 !== 1'b1 || mem_address1 !== 3'd4)
            $display("FAIL ac1_rd_issue: got sel=%b addr=%0d required 1 4", mem_select1, mem_address1);
        else n_pass++;
        tick();
        req_a = 1'b0;
        tick();
        n_checks++;
        if (sb_q.size() == 0)
            $display("FAIL ac1_rd_drop: no expected entry");
        else begin
            e = sb_q.pop_front();
            if (ack_a1 !== 1'b1 || rdata_a1 !== e.rdata)
                $display("FAIL ac1_rd_drop: got ack_a=%b rdata_a=%h required 1 %h", ack_a1, rdata_a1, e.rdata);
            else n_pass++;
        end
        repeat (6) tick();
        n_checks++;
        if (busy1 !== 1'b0 || busy !== 1'b0)
            $display("FAIL ac1_settle: got busy1=%b busy=%b required 0 0", busy1, busy);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = 3'd0; addr_b = 3'd0; wdata_a = 8'd0; wdata_b = 8'd0;
        test_reset();
        test_write_read_a();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_access();
        test_short_latency();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and access sequencer for the 8x8 memory system. It accepts independent read/write requests from two requesters (A and B) and serialises them onto the memory system's single `select`/`op`/`address`/`data_in` port. It waits a fixed access latency, captures read data, and returns a one-cycle acknowledge to the winner. It sits between the requesting logic and the memory system, and is the only driver of the memory system's inputs.

## Interface
- `ACCESS_CYCLES`, default 2: cycles the memory system needs after a `select` pulse before `data_out` is valid or a write is complete. Legal range is 1–15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_a`, `req_b` in 1: request; held high until the matching ack.
- `we_a`, `we_b` in 1: 1 = write, 0 = read; valid while req is high.
- `addr_a`, `addr_b` in 3: word address.
- `wdata_a`, `wdata_b` in 8: write data.
- `ack_a`, `ack_b` out 1: one-cycle completion pulse.
- `rdata_a`, `rdata_b` out 8: read data, valid while ack is high; held until the next read on that port.
- `gnt_a`, `gnt_b` out 1: high from ISSUE through DONE for the winning port.
- `busy` out 1: high in any state other than IDLE.
- `mem_select` out 1: drives the memory system `select`.
- `mem_op` out 1: drives the memory system `op`; 1 = write.
- `mem_address` out 3: drives the memory system `address`.
- `mem_data_in` out 8: drives the memory system `data_in`.
- `mem_data_out` in 8: memory system `data_out`.

## Operation
- FSM states: IDLE → ISSUE → WAIT → DONE → IDLE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, that port wins.
  - If both are high, the port not in `last` wins.
  - On the edge leaving IDLE, latch the winner's we/addr/wdata into the command register, set `last` to the winner, and go to ISSUE.
- ISSUE (1 cycle): `mem_select`=1. `mem_op`, `mem_address` and `mem_data_in` come from the command register. Load wait counter with `ACCESS_CYCLES`-1, then go to WAIT.
- WAIT (`ACCESS_CYCLES` cycles): `mem_select`=0. Command outputs are held stable. The counter decrements each cycle; at 0, go to DONE. On that same edge, for a read, register `mem_data_out` into the winner's rdata.
- DONE (1 cycle): winner's ack=1, then go to IDLE. The requester samples ack on the edge ending DONE and drops req after it. Because of this, the following IDLE cycle never re-grants the same transaction.
- Outside ISSUE/WAIT, `mem_op`, `mem_address` and `mem_data_in` are held at their last values; only `mem_select` qualifies them.
- Requests are sampled only in IDLE:
  - A request that drops while granted does not abort the access; ack still pulses.
  - A request from the losing port waits; it is served next. Back-to-back requests from both ports alternate A, B, A, B.
- Writes leave rdata unchanged. The loser's rdata is never modified.
- Reset (asserted at any time, including mid-access):
  - State returns to IDLE and `last`=B, so A wins the first contention.
  - `mem_select`, `mem_op`, `ack_*`, `gnt_*` and `busy` go to 0.
  - `mem_address`, `mem_data_in` and `rdata_*` go to 0.
  - The counter goes to 0.
  - An interrupted access is dropped with no ack.

## Timing
- A req rising before edge 0 (FSM in IDLE) produces:
  - ISSUE in cycle 1 (`mem_select` high exactly one cycle);
  - WAIT in cycles 2..`ACCESS_CYCLES`+1;
  - DONE/ack in cycle `ACCESS_CYCLES`+2.
- With the default, ack occurs in cycle 4.
- Minimum spacing between `mem_select` pulses is `ACCESS_CYCLES`+3 cycles.
- All outputs are registered or decoded directly from state. No combinational path exists from req/we/addr/wdata to `mem_*` outputs.

## Test plan
- Reset values: hold `rst_n`=0 → all outputs 0. Release; after 5 idle cycles → `busy`=0 and `mem_select` never pulses.
- Single write then read on port A (default parameter):
  - A writes 0xA5 to address 3 → `mem_select` pulses in cycle 1 with `mem_op`=1, `mem_address`=3, `mem_data_in`=0xA5; `ack_a` in cycle 4.
  - A then reads address 3 → `rdata_a`=0xA5 while `ack_a`=1.
- Simultaneous requests after reset: A writes 0x11 to address 0 and B writes 0x22 to address 7 in the same cycle → A is served first; B's `mem_select` pulse comes exactly 5 cycles after A's. Subsequent reads return 0x11 from address 0 and 0x22 from address 7.
- Both ports hold continuous read requests for 4 transactions → grant order A, B, A, B. `rdata_b` is unchanged during A's acks, and vice versa.
- Reset mid-access: assert `rst_n`=0 during WAIT of a B read → no `ack_b`, `rdata_b`=0. After release, a simultaneous A/B request grants A.
- With `ACCESS_CYCLES`=1: ack occurs in cycle 3. Dropping req during WAIT still yields the ack pulse.
